// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared types and constants for the ALU time-sharing controller
package alu_share_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SLL  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SR   = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_AND  = 3'd7;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_SIGN = 1;
  localparam int FLAG_SLTU = 2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; on contention the port not granted last wins
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant
);
  logic last_grant;
  always_comb grant = &valid ? (last_grant ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= 1'b1;
    else if (update) last_grant <= grant[1];
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one external ALU between two requesters,
// one operation in flight, results returned over per-port valid/ready channels
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_select,
  input  logic            req0_rotate,
  input  logic [XLEN-1:0] req0_data1,
  input  logic [XLEN-1:0] req0_data2,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_select,
  input  logic            req1_rotate,
  input  logic [XLEN-1:0] req1_data1,
  input  logic [XLEN-1:0] req1_data2,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic [2:0]      rsp0_flags,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic [2:0]      rsp1_flags,
  output logic [XLEN-1:0] alu_data1,
  output logic [XLEN-1:0] alu_data2,
  output logic [2:0]      alu_select,
  output logic            alu_rotate,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_sign,
  input  logic            alu_sltu,
  output logic            busy
);
  state_t state, state_d;
  logic owner, accept;
  logic [NREQ-1:0] valid, grant, ready, rsp_rdy;
  logic [2:0] alu_flags;
  assign valid = {req1_valid, req0_valid};
  assign rsp_rdy = {rsp1_ready, rsp0_ready};
  assign ready = (state == IDLE && !RESET) ? grant : '0;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign accept = |(valid & ready);
  assign busy = state != IDLE;
  always_comb begin
    alu_flags = '0;
    alu_flags[FLAG_ZERO] = alu_zero;
    alu_flags[FLAG_SIGN] = alu_sign;
    alu_flags[FLAG_SLTU] = alu_sltu;
  end
  rr_arb2 u_arb (
    .clk   (CLK),
    .rst   (RESET),
    .valid (valid),
    .update(accept),
    .grant (grant)
  );
  always_comb
    state_d = state == IDLE ? (accept ? EXEC : IDLE) :
              state == EXEC ? RESP :
              rsp_rdy[owner] ? IDLE : RESP;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      owner       <= 1'b0;
      alu_data1   <= '0;
      alu_data2   <= '0;
      alu_select  <= '0;
      alu_rotate  <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_flags  <= '0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_flags  <= '0;
    end else begin
      if (accept) begin
        owner      <= grant[1];
        alu_data1  <= grant[1] ? req1_data1 : req0_data1;
        alu_data2  <= grant[1] ? req1_data2 : req0_data2;
        alu_select <= grant[1] ? req1_select : req0_select;
        alu_rotate <= grant[1] ? req1_rotate : req0_rotate;
      end
      if (state == EXEC && !owner) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_result;
        rsp0_flags  <= alu_flags;
      end
      if (state == EXEC && owner) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_result;
        rsp1_flags  <= alu_flags;
      end
      if (state == RESP && rsp_rdy[owner]) begin
        if (!owner) rsp0_valid <= 1'b0;
        else rsp1_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: scoreboard bench with a behavioural ALU on the shared port
module tb_alu_share_ctrl;
  import alu_share_pkg::*;
  typedef struct packed {logic [2:0] sel; logic rot; logic [31:0] d1; logic [31:0] d2;} op_t;
  typedef struct packed {logic port; logic [2:0] flags; logic [31:0] res;} exp_t;
  logic CLK = 1'b0, RESET = 1'b1;
  logic req0_valid = 0, req0_ready, req0_rotate = 0, req1_valid = 0, req1_ready, req1_rotate = 0;
  logic [2:0] req0_select = 0, req1_select = 0;
  logic [31:0] req0_data1 = 0, req0_data2 = 0, req1_data1 = 0, req1_data2 = 0;
  logic rsp0_valid, rsp0_ready = 1, rsp1_valid, rsp1_ready = 1;
  logic [31:0] rsp0_result, rsp1_result, alu_data1, alu_data2, alu_result;
  logic [2:0] rsp0_flags, rsp1_flags, alu_select;
  logic alu_rotate, alu_zero, alu_sign, alu_sltu, busy;
  int checks = 0, errors = 0;
  exp_t exp_q[$];
  logic grant_q[$];
  op_t q0[$], q1[$];
  logic [31:0] last_res0 = 0, last_res1 = 0, hold;
  logic [2:0] last_flags0 = 0, last_flags1 = 0;

  always #5 CLK = ~CLK;

  alu_share_ctrl #(.NREQ(2), .XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_select(req0_select),
    .req0_rotate(req0_rotate), .req0_data1(req0_data1), .req0_data2(req0_data2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_select(req1_select),
    .req1_rotate(req1_rotate), .req1_data1(req1_data1), .req1_data2(req1_data2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select), .alu_rotate(alu_rotate),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_sltu(alu_sltu),
    .busy(busy)
  );

  // {sltu, sign, zero, result}; the sltu flag is raised only by compare ops
  function automatic logic [34:0] alu_model(logic [2:0] s, logic r, logic [31:0] a, logic [31:0] b);
    logic [31:0] y;
    logic cmp;
    cmp = (s == ALU_SLT) || (s == ALU_SLTU);
    case (s)
      ALU_ADD:  y = a + b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SR: begin
        if (r) y = $signed(a) >>> b[4:0];
        else y = a >> b[4:0];
      end
      ALU_OR:   y = a | b;
      default:  y = a & b;
    endcase
    return {cmp && (a < b), y[31], y == 32'd0, y};
  endfunction

  assign {alu_sltu, alu_sign, alu_zero, alu_result} = alu_model(alu_select, alu_rotate, alu_data1, alu_data2);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic op_t mk_op(logic [2:0] s, logic r, logic [31:0] a, logic [31:0] b);
    op_t o;
    o.sel = s; o.rot = r; o.d1 = a; o.d2 = b;
    return o;
  endfunction

  task automatic pop_cmp(logic p, logic [31:0] r, logic [2:0] f);
    exp_t e;
    check("rsp_unexpected", exp_q.size() == 0, 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rsp_port", p, e.port);
      check("rsp_result", r, e.res);
      check("rsp_flags", f, e.flags);
      if (p) begin last_res1 = r; last_flags1 = f; end
      else begin last_res0 = r; last_flags0 = f; end
    end
  endtask

  always @(negedge CLK) if (!RESET) begin
    check("one_rsp_valid", rsp0_valid & rsp1_valid, 0);
    if (req0_valid && req0_ready) begin
      exp_q.push_back({1'b0, alu_model(req0_select, req0_rotate, req0_data1, req0_data2)});
      grant_q.push_back(1'b0);
    end
    if (req1_valid && req1_ready) begin
      exp_q.push_back({1'b1, alu_model(req1_select, req1_rotate, req1_data1, req1_data2)});
      grant_q.push_back(1'b1);
    end
    if (rsp0_valid && rsp0_ready) pop_cmp(1'b0, rsp0_result, rsp0_flags);
    if (rsp1_valid && rsp1_ready) pop_cmp(1'b1, rsp1_result, rsp1_flags);
  end

  task automatic drive(logic p, op_t o, logic v);
    if (p) begin
      req1_select = o.sel; req1_rotate = o.rot; req1_data1 = o.d1; req1_data2 = o.d2; req1_valid = v;
    end else begin
      req0_select = o.sel; req0_rotate = o.rot; req0_data1 = o.d1; req0_data2 = o.d2; req0_valid = v;
    end
  endtask

  task automatic send(logic p, op_t o);
    int n = 0;
    @(posedge CLK); #1;
    drive(p, o, 1'b1);
    do begin @(negedge CLK); n++; end while (!(p ? req1_ready : req0_ready) && n < 20);
    check("send_accept", p ? req1_ready : req0_ready, 1);
    @(posedge CLK); #1;
    drive(p, o, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 50) begin @(negedge CLK); n++; end
    check("idle_timeout", busy | (exp_q.size() != 0), 0);
  endtask

  task automatic load(logic p);
    if (p) begin
      if (q1.size() != 0) drive(1'b1, q1[0], 1'b1); else req1_valid = 1'b0;
    end else begin
      if (q0.size() != 0) drive(1'b0, q0[0], 1'b1); else req0_valid = 1'b0;
    end
  endtask

  task automatic run_pair();
    int n = 0;
    logic a0, a1;
    @(posedge CLK); #1;
    load(1'b0); load(1'b1);
    while ((req0_valid || req1_valid) && n < 100) begin
      @(negedge CLK);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      n++;
      @(posedge CLK); #1;
      if (a0) begin void'(q0.pop_front()); load(1'b0); end
      if (a1) begin void'(q1.pop_front()); load(1'b1); end
    end
    check("pair_timeout", req0_valid | req1_valid, 0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req0_valid = 1'b1;
    @(negedge CLK);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_alu_data1", alu_data1, 0);
    check("rst_alu_select", alu_select, 0);
    req0_valid = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    // contention right after reset: port 0 first
    grant_q.delete();
    q0.push_back(mk_op(ALU_XOR, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5));
    q1.push_back(mk_op(ALU_SLTU, 1'b0, 32'd1, 32'd2));
    run_pair();
    check("contend_count", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      check("contend_first", grant_q[0], 0);
      check("contend_second", grant_q[1], 1);
    end
    check("xor_result", last_res0, 0);
    check("xor_flags", last_flags0, 3'b001);
    check("sltu_result", last_res1, 1);
    check("sltu_flags", last_flags1, 3'b100);
    // single ADD with latency checks
    send(1'b0, mk_op(ALU_ADD, 1'b0, 32'd5, 32'd7));
    @(negedge CLK);
    check("exec_busy", busy, 1);
    check("exec_rsp0_valid", rsp0_valid, 0);
    check("exec_alu_data1", alu_data1, 5);
    check("exec_alu_data2", alu_data2, 7);
    check("exec_alu_select", alu_select, ALU_ADD);
    @(negedge CLK);
    check("add_rsp0_valid", rsp0_valid, 1);
    check("add_rsp0_result", rsp0_result, 12);
    check("add_rsp0_flags", rsp0_flags, 0);
    check("add_rsp1_idle", rsp1_valid, 0);
    wait_idle();
    check("add_result", last_res0, 12);
    // arithmetic and logical right shift on port 1
    send(1'b1, mk_op(ALU_SR, 1'b1, 32'h80000000, 32'd4));
    wait_idle();
    check("sra_result", last_res1, 32'hF8000000);
    check("sra_flags", last_flags1, 3'b010);
    send(1'b1, mk_op(ALU_SR, 1'b0, 32'h80000000, 32'd4));
    wait_idle();
    check("srl_result", last_res1, 32'h08000000);
    check("srl_flags", last_flags1, 3'b000);
    // continuous contention alternates
    grant_q.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk_op(3'($urandom_range(0, 7)), 1'($urandom), $urandom, 32'($urandom_range(0, 40))));
      q1.push_back(mk_op(3'($urandom_range(0, 7)), 1'($urandom), $urandom, 32'($urandom_range(0, 40))));
    end
    run_pair();
    check("alt_count", grant_q.size(), 6);
    for (int i = 0; i < grant_q.size(); i++) check("alt_order", grant_q[i], i % 2);
    // response backpressure blocks further accepts
    rsp0_ready = 1'b0;
    send(1'b0, mk_op(ALU_OR, 1'b0, 32'h0F0F0000, 32'h000000F0));
    @(negedge CLK);
    @(negedge CLK);
    hold = rsp0_result;
    check("bp_hold_value", hold, 32'h0F0F00F0);
    @(posedge CLK); #1;
    drive(1'b1, mk_op(ALU_AND, 1'b0, 32'hFFFF0000, 32'h12345678), 1'b1);
    repeat (5) begin
      @(negedge CLK);
      check("bp_rsp0_valid", rsp0_valid, 1);
      check("bp_rsp0_result", rsp0_result, hold);
      check("bp_req1_ready", req1_ready, 0);
    end
    @(posedge CLK); #1;
    rsp0_ready = 1'b1;
    @(negedge CLK);
    check("bp_resp_req1_ready", req1_ready, 0);
    @(negedge CLK);
    check("bp_idle_req1_ready", req1_ready, 1);
    @(posedge CLK); #1;
    req1_valid = 1'b0;
    wait_idle();
    check("bp_and_result", last_res1, 32'h12340000);
    // reset in the middle of an operation discards it
    send(1'b0, mk_op(ALU_ADD, 1'b0, 32'd100, 32'd23));
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    check("rstx_busy", busy, 0);
    check("rstx_rsp0_valid", rsp0_valid, 0);
    check("rstx_rsp0_result", rsp0_result, 0);
    check("rstx_rsp0_flags", rsp0_flags, 0);
    check("rstx_rsp1_result", rsp1_result, 0);
    check("rstx_alu_data1", alu_data1, 0);
    check("rstx_alu_data2", alu_data2, 0);
    check("rstx_alu_select", alu_select, 0);
    check("rstx_alu_rotate", alu_rotate, 0);
    repeat (3) begin
      @(negedge CLK);
      check("rstx_no_rsp", rsp0_valid | rsp1_valid, 0);
    end
    send(1'b0, mk_op(ALU_SLL, 1'b0, 32'h00000003, 32'd8));
    wait_idle();
    check("post_rst_result", last_res0, 32'h00000300);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
